dot_matrix_scanner: RTL and testbench
=====================================

# dot_matrix_scanner

Parametrised row-scan driver for LED dot-matrix panels with a double-buffered frame store. It replaces the fixed 8x8 pattern-table driver. Patterns are written row by row into a back buffer by the game/control logic. The buffers swap only at a frame boundary, so the display never tears. It sits between the game-state logic and the panel pins.

## Interface
- ROWS, 8, number of panel rows (≥2)
- COLS, 8, number of panel columns (≥1)
- SCAN_DIV, 10, clock cycles per row slot (≥2)
- BLANK, 1, cycles at the start of each row slot with everything off (0 ≤ BLANK < SCAN_DIV)
- ROW_ACTIVE_LOW, 1, 1: the selected row is driven 0 and the others 1; 0: inverted
- Derived RW = max(1, $clog2(ROWS))
- clock  in  1  single clock; reset is synchronous and active-high
- reset  in  1  synchronous, active-high reset
- enable  in  1  scanning enabled
- wr_en  in  1  write wr_data into back-buffer row wr_row
- wr_row  in  RW  target row
- wr_data  in  COLS  column bits, 1 = LED on
- swap_req  in  1  request a buffer swap at the next frame boundary
- swap_ack  out  1  one-cycle pulse in the cycle the swap takes effect
- frame_start  out  1  one-cycle pulse when a row-0 slot begins
- dot_row  out  ROWS  row select, one-hot active per ROW_ACTIVE_LOW
- dot_col  out  COLS  column data for the selected row

## Operation
- Storage: two banks of ROWS×COLS bits. `front` selects the displayed bank; the other bank is the back buffer.
- Writes:
  - With wr_en=1 and wr_row<ROWS, the write goes to the bank that is back at the start of that cycle.
  - If wr_row ≥ ROWS, the write is ignored.
  - A write in the same cycle as a swap lands in the old back bank, which becomes front in that cycle.
- Swap:
  - swap_req sets `pending`. Repeated requests while pending merge into one swap.
  - The swap executes at the last cycle of row ROWS-1's slot, or on the next cycle while in IDLE. In that cycle `front` toggles, `pending` clears and swap_ack pulses.
  - If swap_req arrives in the same cycle as the swap, it is consumed by that swap.
- FSM states: IDLE, BLANK, SHOW.
  - IDLE: dot_row all inactive, dot_col=0, row=0, div=0. Goes to BLANK when enable=1.
  - BLANK: dot_row all inactive, dot_col=0. Lasts BLANK cycles and is skipped when BLANK=0. Goes to SHOW.
  - SHOW: dot_row selects `row`; dot_col = front[row]. At the end of the slot, row wraps ROWS-1→0 and the FSM goes to BLANK (or SHOW when BLANK=0).
  - enable=0 in any state: IDLE next cycle. Re-enabling restarts at row 0.
- Counters:
  - div counts 0..SCAN_DIV-1 and wraps.
  - row increments when div wraps.
  - All arithmetic is unsigned with explicit-width wrap.

## Timing
- Reset values: dot_row all inactive (all ones when ROW_ACTIVE_LOW=1), dot_col=0, swap_ack=0, frame_start=0, front=0, pending=0, both banks all 0, state IDLE.
- Reset asserted mid-frame: all of the above apply on the next clock edge, and pending writes and swaps are discarded.
- All outputs are registered.
- A write to the front row currently displayed is visible only after a swap.
- frame_start pulses in the first cycle of row 0's slot, including the restart after IDLE.
- Row slot = SCAN_DIV cycles; frame = ROWS·SCAN_DIV cycles.
- Latency from enable rising to the first frame_start is 1 cycle.
- Within a slot, dot_row changes only at the BLANK→SHOW edge and the slot end, so there is no ghosting.

## Structure
- Shared package `dot_matrix_pkg`: the state enum (IDLE/BLANK/SHOW) and the RW derivation function.
- Natural sub-module: `dot_frame_buffer`, the two-bank storage with a write port, the `front` select and a combinational read of the displayed row.
- The top level holds the FSM, the counters and the swap logic.

## Test plan
All tests use ROWS=8, COLS=8, SCAN_DIV=4, BLANK=1, ROW_ACTIVE_LOW=1.
- Reset, then enable=1: frame_start pulses after 1 cycle. dot_row=8'hFF for 1 cycle, then 8'b01111111 for 3 cycles, then row 1 follows. Frame period is 32 cycles.
- Write rows 0..7 with 8'h3C/8'h42/…, then pulse swap_req mid-frame: swap_ack pulses at the cycle-31 boundary. The next frame shows the new data, and dot_col is 0 before the swap.
- Two swap_req pulses within one frame produce exactly one swap_ack.
- swap_req with enable=0: swap_ack appears 1 cycle later.
- A write with wr_row=9 and RW=3 (wr_row=3'b001 after truncation) hits row 1. With ROWS=6 and wr_row=7, the write is ignored and the banks are unchanged.
- enable dropped at row 4: IDLE next cycle with dot_row=8'hFF and dot_col=0. On re-enable, frame_start pulses and the scan restarts at row 0.
- reset asserted mid-SHOW: every output returns to its reset value at the next edge.

Source files
------------

// File: rtl/dot_matrix_pkg.sv
// dot_matrix_pkg: state encoding and index-width helper shared by the dot-matrix scanner files.
package dot_matrix_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_SHOW} state_t;
    function automatic int rw_of(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/dot_frame_buffer.sv
// dot_frame_buffer: two banks of row bitmaps; writes go to the back bank, reads come from the bank
// that will be displayed after this edge (including a same-cycle write into a bank being swapped in).
module dot_frame_buffer
    import dot_matrix_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int RW   = rw_of(ROWS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [RW-1:0]   wr_row,
    input  logic [COLS-1:0] wr_data,
    input  logic            swap,
    input  logic [RW-1:0]   rd_row,
    output logic [COLS-1:0] rd_data
);
    logic [COLS-1:0] bank [2][ROWS];
    logic front;
    logic wr_ok;
    assign wr_ok = wr_en && (int'(wr_row) < ROWS);
    always_ff @(posedge clock) begin
        if (reset) begin
            front <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                bank[0][r] <= '0;
                bank[1][r] <= '0;
            end
        end else begin
            if (wr_ok) bank[!front][wr_row] <= wr_data;
            if (swap) front <= !front;
        end
    end
    always_comb rd_data = (wr_ok && swap && wr_row == rd_row) ? wr_data : bank[front ^ swap][rd_row];
endmodule

// File: rtl/dot_matrix_scanner.sv
// dot_matrix_scanner: row-scan LED matrix driver; each row slot is BLANK off-cycles then SHOW cycles,
// and back-buffer swaps are deferred to the last cycle of a frame (or taken at once when idle).
module dot_matrix_scanner
    import dot_matrix_pkg::*;
#(
    parameter int ROWS           = 8,
    parameter int COLS           = 8,
    parameter int SCAN_DIV       = 10,
    parameter int BLANK          = 1,
    parameter int ROW_ACTIVE_LOW = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      wr_en,
    input  logic [rw_of(ROWS)-1:0]    wr_row,
    input  logic [COLS-1:0]           wr_data,
    input  logic                      swap_req,
    output logic                      swap_ack,
    output logic                      frame_start,
    output logic [ROWS-1:0]           dot_row,
    output logic [COLS-1:0]           dot_col
);
    localparam int RW = rw_of(ROWS);
    localparam int DW = rw_of(SCAN_DIV);
    localparam logic [RW-1:0]   ROW_LAST = RW'(ROWS - 1);
    localparam logic [DW-1:0]   DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [ROWS-1:0] ROW_OFF  = {ROWS{ROW_ACTIVE_LOW != 0}};
    localparam logic [ROWS-1:0] ROW_TOP  = {1'b1, {(ROWS-1){1'b0}}};

    state_t          state, state_n;
    logic [RW-1:0]   row, row_n;
    logic [DW-1:0]   div, div_n;
    logic            pending, swap, slot_end, frame_n;
    logic [COLS-1:0] rd_col;

    dot_frame_buffer #(.ROWS(ROWS), .COLS(COLS), .RW(RW)) u_fb (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_row  (wr_row),
        .wr_data (wr_data),
        .swap    (swap),
        .rd_row  (row_n),
        .rd_data (rd_col)
    );

    // Outputs are registered from next-state values so they line up with the counters.
    always_comb begin
        slot_end = div == DIV_LAST;
        div_n    = (enable && state != ST_IDLE && !slot_end) ? div + 1'b1 : '0;
        row_n    = (!enable || state == ST_IDLE) ? '0 : !slot_end ? row : (row == ROW_LAST) ? '0 : row + 1'b1;
        state_n  = !enable ? ST_IDLE : (int'(div_n) < BLANK) ? ST_BLANK : ST_SHOW;
        frame_n  = enable && div_n == '0 && row_n == '0;
        swap     = (pending || swap_req) && (state == ST_IDLE || (row == ROW_LAST && slot_end));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            row         <= '0;
            div         <= '0;
            pending     <= 1'b0;
            swap_ack    <= 1'b0;
            frame_start <= 1'b0;
            dot_row     <= ROW_OFF;
            dot_col     <= '0;
        end else begin
            state       <= state_n;
            row         <= row_n;
            div         <= div_n;
            pending     <= (pending || swap_req) && !swap;
            swap_ack    <= swap;
            frame_start <= frame_n;
            dot_row     <= (state_n == ST_SHOW) ? ROW_OFF ^ (ROW_TOP >> row_n) : ROW_OFF;
            dot_col     <= (state_n == ST_SHOW) ? rd_col : '0;
        end
    end
endmodule

// File: tb/tb_dot_matrix_scanner.sv
// tb_dot_matrix_scanner: 8-row and 6-row scanners driven together, checked against a frame-time model.
module tb_dot_matrix_scanner;
    localparam int SD = 4;
    localparam int BL = 1;

    logic clock = 1'b0;
    logic reset = 1'b1, enable = 1'b0, wr_en = 1'b0, swap_req = 1'b0;
    logic [2:0] wr_row = '0;
    logic [7:0] wr_data = '0;
    logic a8, f8, a6, f6;
    logic [7:0] r8, c8, c6;
    logic [5:0] r6;

    int nvec = 0, nbad = 0;
    bit chk_on = 0;

    always #5 clock = ~clock;

    dot_matrix_scanner #(.ROWS(8), .COLS(8), .SCAN_DIV(SD), .BLANK(BL), .ROW_ACTIVE_LOW(1)) d8 (
        .clock(clock), .reset(reset), .enable(enable), .wr_en(wr_en), .wr_row(wr_row),
        .wr_data(wr_data), .swap_req(swap_req), .swap_ack(a8), .frame_start(f8),
        .dot_row(r8), .dot_col(c8));

    dot_matrix_scanner #(.ROWS(6), .COLS(8), .SCAN_DIV(SD), .BLANK(BL), .ROW_ACTIVE_LOW(1)) d6 (
        .clock(clock), .reset(reset), .enable(enable), .wr_en(wr_en), .wr_row(wr_row),
        .wr_data(wr_data), .swap_req(swap_req), .swap_ack(a6), .frame_start(f6),
        .dot_row(r6), .dot_col(c6));

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    // Reference model: position in the frame is just elapsed enabled cycles modulo ROWS*SD.
    int rows_of [2] = '{8, 6};
    bit m_run [2], m_front [2], m_pend [2], e_ack [2], e_fs [2];
    int m_t [2];
    logic [7:0] m_bank [2][2][8];
    logic [7:0] e_row [2], e_col [2];
    int mf, mr, md, msk;
    bit msw, mshow;

    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            mf  = rows_of[i] * SD;
            msk = (1 << rows_of[i]) - 1;
            if (reset) begin
                m_run[i] = 0; m_t[i] = 0; m_front[i] = 0; m_pend[i] = 0;
                for (int b = 0; b < 2; b++)
                    for (int r = 0; r < 8; r++) m_bank[i][b][r] = '0;
                e_ack[i] = 0; e_fs[i] = 0; e_row[i] = 8'(msk); e_col[i] = '0;
            end else begin
                msw = (m_pend[i] || swap_req) && (!m_run[i] || m_t[i] % mf == mf - 1);
                if (wr_en && wr_row < rows_of[i]) m_bank[i][!m_front[i]][wr_row] = wr_data;
                if (msw) m_front[i] = !m_front[i];
                m_pend[i] = (m_pend[i] || swap_req) && !msw;
                m_t[i] = (enable && m_run[i]) ? m_t[i] + 1 : 0;
                m_run[i] = enable;
                mr = (m_t[i] % mf) / SD;
                md = m_t[i] % SD;
                mshow = enable && md >= BL;
                e_ack[i] = msw;
                e_fs[i] = enable && (m_t[i] % mf == 0);
                e_row[i] = 8'(msk ^ (mshow ? (1 << (rows_of[i] - 1 - mr)) : 0));
                e_col[i] = mshow ? m_bank[i][m_front[i]][mr] : 8'h00;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_on) begin
            chk("m8_row", 32'(r8), 32'(e_row[0]));
            chk("m8_col", 32'(c8), 32'(e_col[0]));
            chk("m8_ack", 32'(a8), 32'(e_ack[0]));
            chk("m8_fs",  32'(f8), 32'(e_fs[0]));
            chk("m6_row", 32'(r6), 32'(e_row[1]));
            chk("m6_col", 32'(c6), 32'(e_col[1]));
            chk("m6_ack", 32'(a6), 32'(e_ack[1]));
            chk("m6_fs",  32'(f6), 32'(e_fs[1]));
        end
    end

    typedef struct {
        logic       we;
        logic [2:0] wr;
        logic [7:0] wd;
        logic [7:0] row;
        logic       fs;
    } vec_t;
    vec_t tv [12];

    int nack, at;
    logic fs_at;

    initial begin
        tv[0]  = '{1'b1, 3'd0, 8'h3C, 8'hFF, 1'b1};
        tv[1]  = '{1'b1, 3'd1, 8'h42, 8'h7F, 1'b0};
        tv[2]  = '{1'b1, 3'd2, 8'h81, 8'h7F, 1'b0};
        tv[3]  = '{1'b1, 3'd3, 8'h18, 8'h7F, 1'b0};
        tv[4]  = '{1'b1, 3'd4, 8'h24, 8'hFF, 1'b0};
        tv[5]  = '{1'b1, 3'd5, 8'h5A, 8'hBF, 1'b0};
        tv[6]  = '{1'b1, 3'd6, 8'hA5, 8'hBF, 1'b0};
        tv[7]  = '{1'b1, 3'd7, 8'h66, 8'hBF, 1'b0};
        tv[8]  = '{1'b0, 3'd0, 8'h00, 8'hFF, 1'b0};
        tv[9]  = '{1'b0, 3'd0, 8'h00, 8'hDF, 1'b0};
        tv[10] = '{1'b0, 3'd0, 8'h00, 8'hDF, 1'b0};
        tv[11] = '{1'b0, 3'd0, 8'h00, 8'hDF, 1'b0};

        repeat (2) @(negedge clock);
        chk_on = 1;
        chk("rst_row", 32'(r8), 32'hFF);
        chk("rst_col", 32'(c8), 32'h0);
        chk("rst_ack", 32'(a8), 32'h0);
        chk("rst_fs",  32'(f8), 32'h0);
        reset = 1'b0;

        for (int k = 0; k < 12; k++) begin
            enable = 1'b1; wr_en = tv[k].we; wr_row = tv[k].wr; wr_data = tv[k].wd;
            @(negedge clock);
            chk("tab_row", 32'(r8), 32'(tv[k].row));
            chk("tab_fs",  32'(f8), 32'(tv[k].fs));
            chk("tab_col", 32'(c8), 32'h0);
        end
        wr_en = 1'b0;

        nack = 0; at = -1; fs_at = 1'b0;
        for (int i = 0; i < 40; i++) begin
            swap_req = (i == 0 || i == 5);
            @(negedge clock);
            if (a8 === 1'b1) begin nack++; at = i; fs_at = f8; end
            if (i == 19) chk("col_pre_swap", 32'(c8), 32'h0);
            if (i == 21) chk("col_new_r0", 32'(c8), 32'h3C);
            if (i == 25) chk("col_new_r1", 32'(c8), 32'h42);
        end
        swap_req = 1'b0;
        chk("ack_count", 32'(nack), 32'd1);
        chk("ack_cycle", 32'(at), 32'd20);
        chk("ack_fs", 32'(fs_at), 32'h1);

        for (int i = 0; i < 64 && r8 !== 8'hF7; i++) @(negedge clock);
        chk("find_row4", 32'(r8), 32'hF7);

        enable = 1'b0; wr_en = 1'b1; wr_row = 3'(9); wr_data = 8'hF0;
        @(negedge clock);
        chk("idle_row", 32'(r8), 32'hFF);
        chk("idle_col", 32'(c8), 32'h0);
        chk("idle_fs", 32'(f8), 32'h0);
        chk("idle_noack", 32'(a8), 32'h0);
        wr_row = 3'd7; wr_data = 8'h0F; swap_req = 1'b1;
        @(negedge clock);
        chk("idle_ack8", 32'(a8), 32'h1);
        chk("idle_ack6", 32'(a6), 32'h1);
        swap_req = 1'b0; wr_en = 1'b0;
        @(negedge clock);
        chk("idle_ack_end", 32'(a8), 32'h0);

        enable = 1'b1;
        @(negedge clock);
        chk("re_fs", 32'(f8), 32'h1);
        chk("re_row", 32'(r8), 32'hFF);
        @(negedge clock);
        chk("re_r0_row", 32'(r8), 32'h7F);
        chk("re_r0_col", 32'(c8), 32'h0);
        repeat (4) @(negedge clock);
        chk("re_r1_row", 32'(r8), 32'hBF);
        chk("trunc_r1_col", 32'(c8), 32'hF0);
        chk("d6_r1_row", 32'(r6), 32'h2F);
        chk("d6_r1_col", 32'(c6), 32'hF0);
        repeat (24) @(negedge clock);
        chk("re_r7_row", 32'(r8), 32'hFE);
        chk("re_r7_col", 32'(c8), 32'h0F);
        chk("d6_wrap_row", 32'(r6), 32'h2F);
        chk("d6_wrap_col", 32'(c6), 32'hF0);

        reset = 1'b1; swap_req = 1'b1; wr_en = 1'b1; wr_row = 3'd0; wr_data = 8'hFF;
        @(negedge clock);
        chk("mid_rst_row", 32'(r8), 32'hFF);
        chk("mid_rst_col", 32'(c8), 32'h0);
        chk("mid_rst_ack", 32'(a8), 32'h0);
        chk("mid_rst_fs", 32'(f8), 32'h0);
        chk("mid_rst_row6", 32'(r6), 32'h3F);
        chk("mid_rst_col6", 32'(c6), 32'h0);
        reset = 1'b0; swap_req = 1'b0; wr_en = 1'b0;
        @(negedge clock);
        chk("post_rst_fs", 32'(f8), 32'h1);
        @(negedge clock);
        chk("post_rst_row", 32'(r8), 32'h7F);
        chk("post_rst_col", 32'(c8), 32'h0);

        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 699) == 0);
            enable   = (i % 500 < 470) && ($urandom_range(0, 79) != 0);
            wr_en    = 1'($urandom_range(0, 1));
            wr_row   = 3'($urandom_range(0, 7));
            wr_data  = 8'($urandom);
            swap_req = ($urandom_range(0, 15) == 0);
            @(negedge clock);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
